tag_sched: RTL and testbench

Scheduler for one cache bank's tag store: arbitrates fills, core lookups and software-prefetch lookups into the single tag/metadata port, and runs the line-by-line flush walk after reset and on request. Sits between the bank request queues and the tag-access block: it drives the tag store's lookup/fill/flush/write_prefetch/addr inputs and returns a tagged response aligned with the store's one-cycle read result.

---
 rtl/tag_sched.sv | 198 +++++++++++++++++++
 tb/tb_tag_sched.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tag_sched.sv
// tag_sched: tag-store port scheduler for one cache bank.
//
// Arbitrates fills, core lookups and software-prefetch lookups onto the single
// tag/metadata port. It also runs a line-by-line flush walk after reset and
// whenever a flush is requested. Each grant or walk step produces a tagged
// response one cycle later, aligned with the tag store's read result.
//
// Optional feature: define TAG_SCHED_PERF_EN to enable the perf_pf_unused
// counter. When it is undefined, the output is tied to zero.
//
// Ports:
//   clk, reset (async, active-low)    clock / reset
//   stall                             blocks all grants and walk steps
//   flush_req / flush_busy            flush request pulse / walk active or pending
//   fill_*  / fill_ready              fill request handshake (+ prefetch origin)
//   core_*  / core_ready              core lookup handshake
//   pf_*    / pf_ready                software-prefetch lookup handshake
//   tag_lookup/fill/flush/write_prefetch, tag_addr   tag store controls
//   tag_match, tag_prefetch_used      tag store results, one cycle after issue
//   rsp_valid, rsp_src, rsp_hit       response for the previous-cycle issue
//   perf_pf_unused                    prefetched lines evicted unused
module tag_sched #(
    parameter int unsigned LINES           = 64,
    parameter int unsigned LINE_ADDR_WIDTH = 26,
    parameter int unsigned STARVE_MAX      = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       flush_req,
    output logic                       flush_busy,
    input  logic                       fill_valid,
    output logic                       fill_ready,
    input  logic [LINE_ADDR_WIDTH-1:0] fill_addr,
    input  logic                       fill_prefetch,
    input  logic                       core_valid,
    output logic                       core_ready,
    input  logic [LINE_ADDR_WIDTH-1:0] core_addr,
    input  logic                       pf_valid,
    output logic                       pf_ready,
    input  logic [LINE_ADDR_WIDTH-1:0] pf_addr,
    output logic                       tag_lookup,
    output logic                       tag_fill,
    output logic                       tag_flush,
    output logic                       tag_write_prefetch,
    output logic [LINE_ADDR_WIDTH-1:0] tag_addr,
    input  logic                       tag_match,
    input  logic                       tag_prefetch_used,
    output logic                       rsp_valid,
    output logic [1:0]                 rsp_src,
    output logic                       rsp_hit,
    output logic [31:0]                perf_pf_unused
);

    localparam int unsigned IDX_W = (LINES > 1) ? $clog2(LINES) : 1;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [1:0] SRC_CORE  = 2'd0;
    localparam logic [1:0] SRC_PF    = 2'd1;
    localparam logic [1:0] SRC_FILL  = 2'd2;
    localparam logic [1:0] SRC_FLUSH = 2'd3;

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(LINES - 1);
    localparam logic [7:0]       STARVE_LIM = 8'(STARVE_MAX);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pend_q, pend_d;
    logic [7:0]       starve_q, starve_d;
    logic             armed_q;
    logic             rsp_valid_q, rsp_valid_d;
    logic [1:0]       rsp_src_q, rsp_src_d;

    logic in_walk, active, walk_step, run_ok, pf_prio;
    logic fill_gnt, core_gnt, pf_gnt;

    // armed_q keeps the port quiet for the first cycle after reset release.
    always_comb begin
        in_walk   = (state_q != ST_RUN);
        active    = armed_q && !stall;
        walk_step = active && in_walk;
        run_ok    = active && !in_walk;
        pf_prio   = (starve_q == STARVE_LIM);
        fill_gnt  = run_ok && fill_valid;
        // A starved prefetch outranks core, but never a fill.
        pf_gnt    = run_ok && pf_valid && !fill_valid && (pf_prio || !core_valid);
        core_gnt  = run_ok && core_valid && !fill_valid && !pf_gnt;
    end

    assign fill_ready = fill_gnt;
    assign core_ready = core_gnt;
    assign pf_ready   = pf_gnt;

    assign tag_flush          = walk_step;
    assign tag_fill           = fill_gnt;
    assign tag_lookup         = core_gnt || pf_gnt;
    // Prefetch probes write the prefetch bit so they do not mark a line as used.
    assign tag_write_prefetch = (fill_gnt && fill_prefetch) || pf_gnt;

    always_comb begin
        tag_addr = '0;
        if (walk_step)     tag_addr = LINE_ADDR_WIDTH'(idx_q);
        else if (fill_gnt) tag_addr = fill_addr;
        else if (pf_gnt)   tag_addr = pf_addr;
        else if (core_gnt) tag_addr = core_addr;
    end

    assign flush_busy = in_walk || pend_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pend_d   = pend_q;
        starve_d = starve_q;
        if (in_walk) begin
            if (flush_req) pend_d = 1'b1;
            if (walk_step) begin
                if (idx_q == IDX_LAST) begin
                    idx_d = '0;
                    // A request in the final step folds into the restart; the
                    // pending flag stays set only if both were present.
                    if (pend_q || flush_req) begin
                        state_d = ST_FLUSH;
                        pend_d  = pend_q && flush_req;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        end else begin
            if (flush_req) begin
                state_d = ST_FLUSH;
                idx_d   = '0;
            end
            if (run_ok) begin
                if (pf_gnt)
                    starve_d = '0;
                else if (pf_valid && (starve_q != STARVE_LIM))
                    starve_d = starve_q + 8'd1;
            end
        end
    end

    always_comb begin
        rsp_valid_d = walk_step || fill_gnt || core_gnt || pf_gnt;
        if (walk_step)     rsp_src_d = SRC_FLUSH;
        else if (fill_gnt) rsp_src_d = SRC_FILL;
        else if (pf_gnt)   rsp_src_d = SRC_PF;
        else               rsp_src_d = SRC_CORE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_INIT;
            idx_q       <= '0;
            pend_q      <= 1'b0;
            starve_q    <= '0;
            armed_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_src_q   <= SRC_CORE;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            starve_q    <= starve_d;
            armed_q     <= 1'b1;
            rsp_valid_q <= rsp_valid_d;
            rsp_src_q   <= rsp_src_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_src   = rsp_src_q;
    assign rsp_hit   = rsp_valid_q && (rsp_src_q != SRC_FLUSH) && tag_match;

`ifdef TAG_SCHED_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            perf_q <= '0;
        else if (rsp_valid_q && (rsp_src_q == SRC_FILL) && !tag_prefetch_used)
            perf_q <= perf_q + 32'd1;
    end

    assign perf_pf_unused = perf_q;
`else
    logic unused_prefetch_used;
    assign unused_prefetch_used = tag_prefetch_used;
    assign perf_pf_unused       = '0;
`endif

endmodule

// File: tb/tb_tag_sched.sv
// Randomized scoreboard bench for tag_sched (LINES=8, STARVE_MAX=3).
// A cycle-level reference model predicts readies and tag controls, and queues
// the expected response. A separate monitor pops the queue and checks each
// response, along with the perf counter.
module tb_tag_sched;

    localparam int LINES = 8;
    localparam int AW    = 26;
    localparam int SMAX  = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          stall = 1'b0;
    logic          flush_req = 1'b0;
    logic          flush_busy;
    logic          fill_valid = 1'b0, fill_ready, fill_prefetch = 1'b0;
    logic [AW-1:0] fill_addr = '0;
    logic          core_valid = 1'b0, core_ready;
    logic [AW-1:0] core_addr = '0;
    logic          pf_valid = 1'b0, pf_ready;
    logic [AW-1:0] pf_addr = '0;
    logic          tag_lookup, tag_fill, tag_flush, tag_write_prefetch;
    logic [AW-1:0] tag_addr;
    logic          tag_match = 1'b0, tag_prefetch_used = 1'b0;
    logic          rsp_valid, rsp_hit;
    logic [1:0]    rsp_src;
    logic [31:0]   perf_pf_unused;

    tag_sched #(.LINES(LINES), .LINE_ADDR_WIDTH(AW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush_req(flush_req),
        .flush_busy(flush_busy),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr),
        .fill_prefetch(fill_prefetch),
        .core_valid(core_valid), .core_ready(core_ready), .core_addr(core_addr),
        .pf_valid(pf_valid), .pf_ready(pf_ready), .pf_addr(pf_addr),
        .tag_lookup(tag_lookup), .tag_fill(tag_fill), .tag_flush(tag_flush),
        .tag_write_prefetch(tag_write_prefetch), .tag_addr(tag_addr),
        .tag_match(tag_match), .tag_prefetch_used(tag_prefetch_used),
        .rsp_valid(rsp_valid), .rsp_src(rsp_src), .rsp_hit(rsp_hit),
        .perf_pf_unused(perf_pf_unused)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %0h required %0h", name, cyc, act, exp);
        end
    endfunction

    typedef struct {
        int due;
        int src;
    } exp_t;
    exp_t sbq[$];

    // Reference model: walk_pos < 0 means the bank is serving requests.
    int walk_pos = 0;
    bit pend = 1'b0;
    bit armed = 1'b0;
    int starve = 0;

    always @(negedge clk) begin
        int src;
        logic [AW-1:0] ea;
        if (!reset) begin
            chk("rst_flush_busy", flush_busy, 1);
            chk("rst_tag_flush", tag_flush, 0);
            chk("rst_tag_fill", tag_fill, 0);
            chk("rst_tag_lookup", tag_lookup, 0);
            chk("rst_readies", {fill_ready, core_ready, pf_ready}, 0);
            walk_pos = 0;
            pend = 1'b0;
            armed = 1'b0;
            starve = 0;
        end else begin
            src = -1;
            ea = '0;
            if (armed && !stall) begin
                if (walk_pos >= 0) src = 3;
                else if (fill_valid) src = 2;
                else if (pf_valid && (starve == SMAX || !core_valid)) src = 1;
                else if (core_valid) src = 0;
            end
            chk("flush_busy", flush_busy, (walk_pos >= 0) || pend);
            chk("fill_ready", fill_ready, src == 2);
            chk("core_ready", core_ready, src == 0);
            chk("pf_ready", pf_ready, src == 1);
            chk("tag_flush", tag_flush, src == 3);
            chk("tag_fill", tag_fill, src == 2);
            chk("tag_lookup", tag_lookup, (src == 0) || (src == 1));
            chk("tag_write_prefetch", tag_write_prefetch, (src == 1) || (src == 2 && fill_prefetch));
            case (src)
                3: ea = AW'(walk_pos);
                2: ea = fill_addr;
                1: ea = pf_addr;
                0: ea = core_addr;
                default: ea = '0;
            endcase
            if (src >= 0) begin
                chk("tag_addr", tag_addr, ea);
                sbq.push_back('{cyc + 1, src});
            end
            // advance model to the next cycle
            if (walk_pos >= 0) begin
                if (src == 3 && walk_pos == LINES - 1) begin
                    if (pend || flush_req) begin
                        walk_pos = 0;
                        pend = pend && flush_req;
                    end else begin
                        walk_pos = -1;
                    end
                end else begin
                    if (src == 3) walk_pos++;
                    if (flush_req) pend = 1'b1;
                end
            end else begin
                if (armed && !stall) begin
                    if (src == 1) starve = 0;
                    else if (pf_valid && starve < SMAX) starve++;
                end
                if (flush_req) walk_pos = 0;
            end
            armed = 1'b1;
        end
    end

    // Monitor: responses and the perf counter.
    bit [31:0] exp_perf = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            sbq.delete();
            exp_perf = '0;
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_perf", perf_pf_unused, 0);
        end else begin
            chk("perf_pf_unused", perf_pf_unused, exp_perf);
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                chk("rsp_valid", rsp_valid, 1);
                chk("rsp_src", rsp_src, e.src);
                chk("rsp_hit", rsp_hit, (e.src != 3) && tag_match);
`ifdef TAG_SCHED_PERF_EN
                if (e.src == 2 && !tag_prefetch_used) exp_perf++;
`endif
            end else begin
                chk("rsp_idle", rsp_valid, 0);
            end
        end
    end

    task automatic step(input bit fv, input bit cv, input bit pv, input bit st, input bit fr);
        @(posedge clk);
        #1;
        fill_valid = fv;
        core_valid = cv;
        pf_valid = pv;
        stall = st;
        flush_req = fr;
        fill_addr = AW'($urandom);
        core_addr = AW'($urandom);
        pf_addr = AW'($urandom);
        fill_prefetch = ($urandom % 2) == 1;
        tag_match = ($urandom % 2) == 1;
        tag_prefetch_used = ($urandom % 2) == 1;
    endtask

    task automatic rand_steps(input int n, input int stall_pct, input int flush_per);
        for (int i = 0; i < n; i++)
            step(($urandom % 3) == 0, ($urandom % 2) == 1, ($urandom % 2) == 1,
                 ($urandom % 100) < stall_pct, ($urandom % flush_per) == 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        // post-reset walk with core requests waiting
        repeat (14) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // all three valid: fill, then core, then prefetch
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // starvation: core and prefetch held
        repeat (10) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        // flush, then a second request at walk index 3
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (20) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // stall mid-walk
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // fills with mixed prefetch-used results
        repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rand_steps(2000, 10, 80);
        // reset mid-walk with a flush pending
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (12) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // reset in a grant cycle
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 reset = 1'b0;
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        rand_steps(1500, 20, 40);
        repeat (20) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
